// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared widths, Tuse/Tnew constants and MDU latencies.
//   AW_DEF / TW_DEF       : default register-address and Tuse/Tnew widths
//   TUSE_NONE             : Tuse for an operand that is never read
//   TNEW_ALU / TNEW_LOAD  : Tnew of ALU and load producers on reaching E
//   MULT_CYC_DEF / DIV_CYC_DEF : MDU busy cycles for mult / div
//   CW_DEF                : default stall counter width
package hazard_scoreboard_pkg;
    localparam int AW_DEF       = 5;
    localparam int TW_DEF       = 3;
    localparam int TUSE_NONE    = 7;
    localparam int TNEW_ALU     = 1;
    localparam int TNEW_LOAD    = 2;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int CW_DEF       = 16;
endpackage

// File: rtl/hazard_scoreboard_stage_cmp.sv
// hazard_stage_cmp: compares the D-stage rs/rt sources against one shadow entry.
//   rs_i, rt_i           : source register indices of the D instruction
//   tuse_rs_i, tuse_rt_i : cycles until D needs each source
//   addr_i, tnew_i       : destination and remaining Tnew of the tracked entry
//   hazard_o             : entry will not have its result ready in time
module hazard_stage_cmp
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rt_i,
    input  logic [TW-1:0] tuse_rs_i,
    input  logic [TW-1:0] tuse_rt_i,
    input  logic [AW-1:0] addr_i,
    input  logic [TW-1:0] tnew_i,
    output logic          hazard_o
);
    // Register 0 is hard-wired, so a match on it is never a dependency.
    assign hazard_o = (rs_i == addr_i && rs_i != '0 && tuse_rs_i < tnew_i) ||
                      (rt_i == addr_i && rt_i != '0 && tuse_rt_i < tnew_i);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall unit with a shadow (dest, Tnew) pipeline,
// MDU busy interlock and a saturating stall counter.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   D_rs, D_rt, Tuse_rs/rt     : D-stage sources and when they are needed
//   D_RegAddr, D_Tnew          : D-stage destination and its Tnew in E
//   D_md_start, D_md_div       : D is mult/div; div selects the longer latency
//   D_md_use                   : D touches HI/LO or the MDU
//   Stall                      : combinational freeze of PC/F/D, bubble into E
//   md_busy                    : MDU still computing
//   stage_addr, stage_tnew     : flattened shadow entries, stage 1 in the LSBs
//   stall_cnt                  : saturating count of stalled cycles
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int AW       = AW_DEF,
    parameter int TW       = TW_DEF,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AW-1:0]        D_rs,
    input  logic [AW-1:0]        D_rt,
    input  logic [TW-1:0]        Tuse_rs,
    input  logic [TW-1:0]        Tuse_rt,
    input  logic [AW-1:0]        D_RegAddr,
    input  logic [TW-1:0]        D_Tnew,
    input  logic                 D_md_start,
    input  logic                 D_md_div,
    input  logic                 D_md_use,
    output logic                 Stall,
    output logic                 md_busy,
    output logic [NSTAGE*AW-1:0] stage_addr,
    output logic [NSTAGE*TW-1:0] stage_tnew,
    output logic [CW-1:0]        stall_cnt
);
    // Sized for the longer of the two latencies so either value fits.
    localparam int MW = $clog2((DIV_CYC > MULT_CYC ? DIV_CYC : MULT_CYC) + 1);

    logic [AW-1:0]     addr_q [NSTAGE];
    logic [AW-1:0]     addr_d [NSTAGE];
    logic [TW-1:0]     tnew_q [NSTAGE];
    logic [TW-1:0]     tnew_d [NSTAGE];
    logic              md1_q, md1_d;
    logic [MW-1:0]     md_cnt_q, md_cnt_d;
    logic [CW-1:0]     stall_cnt_q, stall_cnt_d;
    logic [NSTAGE-1:0] hazard;
    logic              md_stall;

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        hazard_stage_cmp #(.AW(AW), .TW(TW)) u_cmp (
            .rs_i      (D_rs),
            .rt_i      (D_rt),
            .tuse_rs_i (Tuse_rs),
            .tuse_rt_i (Tuse_rt),
            .addr_i    (addr_q[g]),
            .tnew_i    (tnew_q[g]),
            .hazard_o  (hazard[g])
        );
        assign stage_addr[g*AW +: AW] = addr_q[g];
        assign stage_tnew[g*TW +: TW] = tnew_q[g];
    end

    assign md_busy   = md_cnt_q != '0;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        md_stall  = D_md_use && (md_busy || md1_q);
        Stall     = (|hazard) || md_stall;
        // A stalled D instruction is replaced by a bubble in E.
        addr_d[0] = Stall ? '0 : D_RegAddr;
        tnew_d[0] = Stall ? '0 : D_Tnew;
        md1_d     = !Stall && D_md_start;
        for (int k = 1; k < NSTAGE; k++) begin
            addr_d[k] = addr_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
        end
        md_cnt_d    = (D_md_start && !Stall) ? (D_md_div ? MW'(DIV_CYC) : MW'(MULT_CYC)) :
                      md_busy ? md_cnt_q - MW'(1) : md_cnt_q;
        stall_cnt_d = (Stall && !(&stall_cnt_q)) ? stall_cnt_q + CW'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                addr_q[k] <= '0;
                tnew_q[k] <= '0;
            end
            md1_q       <= 1'b0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                addr_q[k] <= addr_d[k];
                tnew_q[k] <= tnew_d[k];
            end
            md1_q       <= md1_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NSTAGE = 3;
    localparam int AW     = 5;
    localparam int TW     = 3;
    localparam int CW     = 4;

    logic                 clk;
    logic                 rst_n;
    logic [AW-1:0]        D_rs, D_rt, D_RegAddr;
    logic [TW-1:0]        Tuse_rs, Tuse_rt, D_Tnew;
    logic                 D_md_start, D_md_div, D_md_use;
    logic                 Stall, md_busy;
    logic [NSTAGE*AW-1:0] stage_addr;
    logic [NSTAGE*TW-1:0] stage_tnew;
    logic [CW-1:0]        stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt;

    hazard_scoreboard #(
        .NSTAGE(NSTAGE), .AW(AW), .TW(TW),
        .MULT_CYC(5), .DIV_CYC(10), .CW(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .Tuse_rs    (Tuse_rs),
        .Tuse_rt    (Tuse_rt),
        .D_RegAddr  (D_RegAddr),
        .D_Tnew     (D_Tnew),
        .D_md_start (D_md_start),
        .D_md_div   (D_md_div),
        .D_md_use   (D_md_use),
        .Stall      (Stall),
        .md_busy    (md_busy),
        .stage_addr (stage_addr),
        .stage_tnew (stage_tnew),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int rs, input int trs, input int rt, input int trt,
                         input int ra, input int tn, input bit st, input bit dv, input bit us);
        D_rs       = AW'(rs);
        Tuse_rs    = TW'(trs);
        D_rt       = AW'(rt);
        Tuse_rt    = TW'(trt);
        D_RegAddr  = AW'(ra);
        D_Tnew     = TW'(tn);
        D_md_start = st;
        D_md_div   = dv;
        D_md_use   = us;
        #1;
    endtask

    task automatic idle();
        drive(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        chk("rst_stall", Stall, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_addr", stage_addr, 0);
        chk("rst_tnew", stage_tnew, 0);
        rst_n = 1'b1;
        step();

        // Load-use: lw $8 then a consumer of $8 at Tuse 0.
        drive(0, TUSE_NONE, 0, TUSE_NONE, 8, TNEW_LOAD, 0, 0, 0);
        chk("lw_issue_stall", Stall, 0);
        step();
        chk("lw_s1_addr", stage_addr[AW-1:0], 8);
        chk("lw_s1_tnew", stage_tnew[TW-1:0], 2);
        drive(8, 0, 0, TUSE_NONE, 9, TNEW_ALU, 0, 0, 0);
        chk("lu_stall_c1", Stall, 1);
        step();
        chk("lu_stall_c2", Stall, 1);
        chk("lu_bubble_addr", stage_addr[AW-1:0], 0);
        chk("lu_s2_tnew", stage_tnew[2*TW-1:TW], 1);
        step();
        chk("lu_stall_c3", Stall, 0);
        chk("lu_cnt", stall_cnt, 2);
        chk("lu_s3_addr", stage_addr, 15'h2000);
        chk("lu_s3_tnew", stage_tnew, 0);
        step();
        chk("lu_consumer_s1", stage_addr[AW-1:0], 9);

        // Producer writing $0 never stalls.
        idle();
        do_reset();
        drive(0, TUSE_NONE, 0, TUSE_NONE, 0, TNEW_LOAD, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 3, TNEW_ALU, 0, 0, 0);
        chk("r0_stall", Stall, 0);
        step();
        chk("r0_stall_next", Stall, 0);
        chk("r0_cnt", stall_cnt, 0);

        // ALU producer: Tuse 1 forwards, Tuse 0 stalls one cycle.
        idle();
        do_reset();
        drive(0, TUSE_NONE, 0, TUSE_NONE, 5, TNEW_ALU, 0, 0, 0);
        step();
        drive(0, TUSE_NONE, 5, 1, 0, 0, 0, 0, 0);
        chk("alu_fwd", Stall, 0);
        drive(0, TUSE_NONE, 5, 0, 0, 0, 0, 0, 0);
        chk("alu_tuse0", Stall, 1);
        step();
        chk("alu_release", Stall, 0);
        chk("alu_cnt", stall_cnt, 1);
        chk("alu_s2_tnew", stage_tnew[2*TW-1:TW], 0);

        // Div interlock: mflo behind a div stalls 10 cycles.
        idle();
        do_reset();
        drive(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 1, 1);
        chk("div_issue", Stall, 0);
        step();
        chk("div_busy", md_busy, 1);
        drive(0, TUSE_NONE, 0, TUSE_NONE, 10, TNEW_ALU, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("div_stall_%0d", i), {md_busy, Stall}, 2'b11);
            step();
        end
        chk("div_done_stall", Stall, 0);
        chk("div_done_busy", md_busy, 0);
        chk("div_cnt", stall_cnt, 10);
        step();
        chk("mflo_issued", stage_addr[AW-1:0], 10);

        // Mult interlock length.
        idle();
        do_reset();
        drive(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 0, 1);
        step();
        drive(0, TUSE_NONE, 0, TUSE_NONE, 11, TNEW_ALU, 0, 0, 1);
        cnt = 0;
        while (Stall && cnt < 20) begin
            cnt++;
            step();
        end
        chk("mult_stall_len", cnt, 5);

        // Back-to-back divs: second waits, then issues; counter saturates.
        idle();
        do_reset();
        drive(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 1, 1);
        step();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("b2b_a_%0d", i), Stall, 1);
            step();
        end
        chk("b2b_issue", Stall, 0);
        chk("b2b_cnt10", stall_cnt, 10);
        step();
        chk("b2b_reload", md_busy, 1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("b2b_b_%0d", i), Stall, 1);
            if (i == 4) chk("sat_cnt14", stall_cnt, 14);
            step();
        end
        chk("sat_cnt15", stall_cnt, 15);

        // Asynchronous reset in the middle of a div.
        idle();
        do_reset();
        drive(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, 1, 1, 1);
        step();
        drive(0, TUSE_NONE, 0, TUSE_NONE, 12, TNEW_ALU, 0, 0, 1);
        step();
        step();
        chk("mid_div_stall", Stall, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", md_busy, 0);
        chk("arst_stall", Stall, 0);
        chk("arst_cnt", stall_cnt, 0);
        chk("arst_addr", stage_addr, 0);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", md_busy, 0);
        chk("post_rst_issue", stage_addr[AW-1:0], 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
